// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, state encoding and fetch-fault decoding for the
// instruction-memory responder and its loader.
package imem_pkg;

    // addi x0,x0,0 -- returned whenever no real instruction can be supplied
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    // Loader FSM encoding: memory is either being filled or serving fetches
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } imem_state_e;

    // Bit positions within a fetch-fault reason vector
    localparam int FAULT_ALIGN = 0;
    localparam int FAULT_RANGE = 1;
    localparam int FAULT_W     = 2;

    // Classify a fetch address: misaligned, and/or outside [base, base+4*depth)
    function automatic logic [FAULT_W-1:0] fetch_fault_reason(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] depth
    );
        logic [FAULT_W-1:0] r;
        r = '0;
        r[FAULT_ALIGN] = (addr[1:0] != 2'b00);
        r[FAULT_RANGE] = (addr < base) || (((addr - base) >> 2) >= depth);
        return r;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: write side of the instruction memory. Owns the LOAD/RUN FSM,
// the write pointer, the loaded-word count, the per-word valid bitmap and the
// streaming load handshake. A reload pulse discards the program.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic             load_last,
    input  logic             reload,
    output logic             load_ready,
    output logic             load_done,
    output logic [CW-1:0]    word_count,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [DEPTH-1:0] valid
);

    imem_state_e      state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             accept;

    // A same-cycle reload wins over any offered beat, which is then dropped
    assign accept = (state_q == ST_LOAD) && load_valid && !reload;

    // Loader state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_LOAD;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Next state: advance on accepted beats, leave LOAD on last beat or when full
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (reload) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
            if (load_last || (&wr_ptr_q)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Per-word valid flags: set when that word is written, cleared by reload
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_valid
            assign valid_d[gi] = reload ? 1'b0
                               : (valid_q[gi] | (accept && (wr_ptr_q == AW'(gi))));
        end
    endgenerate

    assign load_ready = (state_q == ST_LOAD);
    assign load_done  = (state_q == ST_RUN);
    assign word_count = count_q;
    assign wr_en      = accept;
    assign wr_addr    = wr_ptr_q;
    assign valid      = valid_q;

endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the fetch side of the core.
// Returns the word at InstAddr one clock later, substituting NOP_WORD for
// stalled-out, unloaded or faulting fetches. Loading is delegated to
// imem_loader. Optional macro IMEM_STICKY_FAULT_EN makes fetch_fault sticky
// in RUN until reset or reload.
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              InstAddr,
    input  logic                     stall,
    output logic [31:0]              Instruction,
    output logic                     inst_valid,
    output logic                     fetch_fault,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [31:0]              load_data,
    input  logic                     load_last,
    input  logic                     reload,
    output logic                     load_done,
    output logic [$clog2(DEPTH):0]   word_count
);

    localparam int AW = $clog2(DEPTH);

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DEPTH-1:0]   valid;
    logic [AW-1:0]      rd_idx;
    logic [FAULT_W-1:0] reason;
    logic               rd_en;
    logic               sticky_hold;

    logic [31:0]        mem_q [DEPTH];
    logic [31:0]        rdata_q;
    logic               use_mem_q, use_mem_d;
    logic               inst_valid_q, inst_valid_d;
    logic               fault_q, fault_d;

    imem_loader #(.DEPTH(DEPTH)) u_loader (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_last  (load_last),
        .reload     (reload),
        .load_ready (load_ready),
        .load_done  (load_done),
        .word_count (word_count),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .valid      (valid)
    );

    assign reason = fetch_fault_reason(InstAddr, BASE_ADDR, 32'(DEPTH));
    assign rd_idx = AW'((InstAddr - BASE_ADDR) >> 2);
    assign rd_en  = load_done && !stall && !reload;

`ifdef IMEM_STICKY_FAULT_EN
    assign sticky_hold = fault_q;
`else
    assign sticky_hold = 1'b0;
`endif

    // Memory write port, fed by the loader
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= load_data;
        end
    end

    // Registered read port; held while stalled so Instruction stays stable
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata_q <= mem_q[rd_idx];
        end
    end

    // Fetch qualifiers: LOAD/reload clears them, stall holds them
    always_comb begin
        use_mem_d    = use_mem_q;
        inst_valid_d = inst_valid_q;
        fault_d      = fault_q;
        if (reload || !load_done) begin
            use_mem_d    = 1'b0;
            inst_valid_d = 1'b0;
            fault_d      = 1'b0;
        end else if (!stall) begin
            inst_valid_d = 1'b1;
            if (sticky_hold || (|reason)) begin
                use_mem_d = 1'b0;
                fault_d   = 1'b1;
            end else begin
                use_mem_d = valid[rd_idx];
                fault_d   = 1'b0;
            end
        end
    end

    // Fetch qualifier registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            use_mem_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            use_mem_q    <= use_mem_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
        end
    end

    // Output word is the registered read data, or NOP when it must not be used
    assign Instruction = use_mem_q ? rdata_q : NOP_WORD;
    assign inst_valid  = inst_valid_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed bench for imem_responder with a behavioural
// model checked every cycle plus hand-computed literal expectations.
module tb_imem_responder;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_STICKY_FAULT_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] InstAddr = '0;
    logic        stall = 1'b0;
    logic [31:0] Instruction;
    logic        inst_valid;
    logic        fetch_fault;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        reload = 1'b0;
    logic        load_done;
    logic [8:0]  word_count;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .NOP_WORD(NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .InstAddr    (InstAddr),
        .stall       (stall),
        .Instruction (Instruction),
        .inst_valid  (inst_valid),
        .fetch_fault (fetch_fault),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .reload      (reload),
        .load_done   (load_done),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit [31:0] m_mem [DEPTH];
    bit        m_loaded [DEPTH];
    int        m_count = 0;
    bit        m_run = 1'b0;
    bit [31:0] m_instr = NOP;
    bit        m_iv = 1'b0;
    bit        m_ff = 1'b0;

    task automatic model_clear();
        m_run = 1'b0;
        m_count = 0;
        foreach (m_loaded[i]) m_loaded[i] = 1'b0;
        m_instr = NOP;
        m_iv = 1'b0;
        m_ff = 1'b0;
    endtask

    task automatic model_step();
        longint unsigned a;
        longint unsigned idx;
        bit bad;
        if (reload) begin
            model_clear();
        end else if (!m_run) begin
            if (load_valid) begin
                m_mem[m_count] = load_data;
                m_loaded[m_count] = 1'b1;
                m_count++;
                if (load_last || m_count == DEPTH) m_run = 1'b1;
            end
            m_instr = NOP;
            m_iv = 1'b0;
            m_ff = 1'b0;
        end else if (!stall) begin
            a = longint'(InstAddr);
            bad = (a % 4 != 0) || (a < longint'(BASE)) ||
                  ((a - longint'(BASE)) / 4 >= DEPTH);
            m_iv = 1'b1;
            if (bad || (STICKY && m_ff)) begin
                m_instr = NOP;
                m_ff = 1'b1;
            end else begin
                idx = (a - longint'(BASE)) / 4;
                m_ff = 1'b0;
                m_instr = m_loaded[idx] ? m_mem[idx] : NOP;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_clear();
        else model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model.Instruction", Instruction, m_instr);
            chk("model.inst_valid", 32'(inst_valid), 32'(m_iv));
            chk("model.fetch_fault", 32'(fetch_fault), 32'(m_ff));
            chk("model.load_ready", 32'(load_ready), 32'(!m_run));
            chk("model.load_done", 32'(load_done), 32'(m_run));
            chk("model.word_count", 32'(word_count), 32'(m_count));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data = d;
        load_last = last;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last = 1'b0;
        $display("beat data=%h last=%0b count=%0d", d, last, word_count);
    endtask

    task automatic fetch(input logic [31:0] addr);
        InstAddr = addr;
        stall = 1'b0;
        @(posedge clk);
        #1;
        $display("fetch addr=%h instr=%h valid=%0b fault=%0b", addr, Instruction, inst_valid, fetch_fault);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        $display("reload count=%0d", word_count);
    endtask

    logic [31:0] exp_i;
    logic [31:0] exp_f;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.Instruction", Instruction, NOP);
        chk("rst.inst_valid", 32'(inst_valid), 0);
        chk("rst.fetch_fault", 32'(fetch_fault), 0);
        chk("rst.load_ready", 32'(load_ready), 1);
        chk("rst.load_done", 32'(load_done), 0);
        chk("rst.word_count", 32'(word_count), 0);
        reset = 1'b1;
        cmp_en = 1'b1;

        // Three-word program
        beat(32'hFFFFF137, 1'b0);
        beat(32'hFFFFE0B7, 1'b0);
        beat(32'h00110233, 1'b1);
        chk("prog.word_count", 32'(word_count), 3);
        chk("prog.load_done", 32'(load_done), 1);
        chk("prog.load_ready", 32'(load_ready), 0);
        fetch(32'h0);
        chk("f0.Instruction", Instruction, 32'hFFFFF137);
        chk("f0.inst_valid", 32'(inst_valid), 1);
        fetch(32'h4);
        chk("f4.Instruction", Instruction, 32'hFFFFE0B7);
        fetch(32'h8);
        chk("f8.Instruction", Instruction, 32'h00110233);
        fetch(32'hC);
        chk("fC.Instruction", Instruction, NOP);
        chk("fC.fetch_fault", 32'(fetch_fault), 0);
        chk("fC.inst_valid", 32'(inst_valid), 1);

        // Stall holds the previous fetch result
        fetch(32'h0);
        stall = 1'b1;
        InstAddr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall.Instruction", Instruction, 32'hFFFFF137);
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("unstall.Instruction", Instruction, 32'hFFFFE0B7);

        // Faulting fetches
        fetch(32'h402);
        chk("mis.Instruction", Instruction, NOP);
        chk("mis.fetch_fault", 32'(fetch_fault), 1);
        fetch(32'(4 * DEPTH));
        chk("oor.Instruction", Instruction, NOP);
        chk("oor.fetch_fault", 32'(fetch_fault), 1);
        fetch(32'h0);
        exp_i = STICKY ? NOP : 32'hFFFFF137;
        exp_f = STICKY ? 32'd1 : 32'd0;
        chk("after_fault.Instruction", Instruction, exp_i);
        chk("after_fault.fetch_fault", 32'(fetch_fault), exp_f);

        // Reload in RUN with a same-cycle beat: beat is dropped
        reload = 1'b1;
        load_valid = 1'b1;
        load_data = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        reload = 1'b0;
        load_valid = 1'b0;
        chk("reload.word_count", 32'(word_count), 0);
        chk("reload.inst_valid", 32'(inst_valid), 0);
        chk("reload.Instruction", Instruction, NOP);
        chk("reload.fetch_fault", 32'(fetch_fault), 0);
        chk("reload.load_ready", 32'(load_ready), 1);
        beat(32'h00500093, 1'b1);
        fetch(32'h0);
        chk("rl0.Instruction", Instruction, 32'h00500093);
        fetch(32'h4);
        chk("rl4.Instruction", Instruction, NOP);
        chk("rl4.fetch_fault", 32'(fetch_fault), 0);
        chk("rl4.inst_valid", 32'(inst_valid), 1);

        // Fill to capacity without load_last
        pulse_reload();
        for (int i = 0; i < DEPTH; i++) begin
            beat(32'hA5A5_0000 | 32'(i), 1'b0);
        end
        chk("full.load_ready", 32'(load_ready), 0);
        chk("full.load_done", 32'(load_done), 1);
        chk("full.word_count", 32'(word_count), 256);
        beat(32'hCAFEF00D, 1'b0);
        chk("extra.word_count", 32'(word_count), 256);
        fetch(32'h3FC);
        chk("full_last.Instruction", Instruction, 32'hA5A5_00FF);
        fetch(32'h0);
        chk("full_first.Instruction", Instruction, 32'hA5A5_0000);

        // Asynchronous reset in the middle of a load
        pulse_reload();
        for (int i = 0; i < 5; i++) begin
            beat(32'h0010_0093 + 32'(i), 1'b0);
        end
        chk("pre_rst.word_count", 32'(word_count), 5);
        load_valid = 1'b1;
        load_data = 32'h12345678;
        #2;
        reset = 1'b0;
        #1;
        chk("arst.word_count", 32'(word_count), 0);
        chk("arst.load_ready", 32'(load_ready), 1);
        chk("arst.load_done", 32'(load_done), 0);
        chk("arst.inst_valid", 32'(inst_valid), 0);
        chk("arst.Instruction", Instruction, NOP);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        reset = 1'b1;
        beat(32'h00A00513, 1'b1);
        fetch(32'h0);
        chk("reload_after_rst.Instruction", Instruction, 32'h00A00513);

        // Misaligned fetch followed by aligned fetches
        fetch(32'h2);
        chk("mis2.fetch_fault", 32'(fetch_fault), 1);
        fetch(32'h0);
        exp_i = STICKY ? NOP : 32'h00A00513;
        chk("sticky.Instruction", Instruction, exp_i);
        chk("sticky.fetch_fault", 32'(fetch_fault), exp_f);
        chk("sticky.inst_valid", 32'(inst_valid), 1);
        pulse_reload();
        chk("sticky_clr.fetch_fault", 32'(fetch_fault), 0);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
